// File: rtl/vend_pkg.sv
// Shared types for the vending dispense scheduler.
//   item_t     : 2-bit item code, ITEM_NONE means "reject, nothing to dispense"
//   sched_st_t : scheduler FSM states
package vend_pkg;

  typedef logic [1:0] item_t;

  localparam item_t ITEM_NONE = 2'd0;
  localparam item_t ITEM_G1   = 2'd1;
  localparam item_t ITEM_G2   = 2'd2;
  localparam item_t ITEM_G3   = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    WAIT,
    ACK,
    GAPW
  } sched_st_t;

endpackage

// File: rtl/vend_rr_arb.sv
// Round-robin arbiter (purely combinational).
// Searches req starting at ptr+1 with wrap-around; the station at ptr (the one
// served last) is therefore considered last.
//   req     in  N_STA : request vector
//   ptr     in  IDXW  : index of the most recently granted station
//   gnt     out N_STA : one-hot grant (all zero when no request)
//   idx     out IDXW  : index of the granted station (0 when no request)
//   any_req out 1     : at least one request present
module vend_rr_arb #(
  parameter  int N_STA = 4,
  localparam int IDXW  = $clog2(N_STA)
) (
  input  logic [N_STA-1:0] req,
  input  logic [IDXW-1:0]  ptr,
  output logic [N_STA-1:0] gnt,
  output logic [IDXW-1:0]  idx,
  output logic             any_req
);

  logic        found;
  int unsigned cand;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    cand    = 0;
    any_req = |req;
    for (int unsigned k = 1; k <= N_STA; k++) begin
      cand = (32'(ptr) + k) % N_STA;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDXW'(cand);
      end
    end
  end

endmodule

// File: rtl/vend_dispense_sched.sv
// Dispense scheduler: shares one dispenser among N_STA vending stations.
// A round-robin pick among requesting stations is granted, the dispenser is
// started, and the result (ok / rejected / aborted) is acked to that station.
// All outputs come straight from flops (next values derived from next state).
//   clk, rst    : clock, asynchronous active-high reset
//   req_valid   : per-station sale request, held until req_ready
//   req_item    : per-station item code, bits [2i+1:2i]
//   req_ready   : one-cycle accept pulse to the granted station
//   disp_start  : one-cycle dispenser start pulse
//   disp_item   : item being dispensed (stable through the transaction)
//   disp_sta    : granted station index (stable with disp_item)
//   disp_done   : dispenser completion pulse, honoured only while waiting
//   ack_valid   : one-cycle result pulse to the granted station
//   ack_ok      : result qualifier, 1 = dispensed
//   err_tmo     : pulses with an ack caused by a dispenser timeout
// Build option: VEND_SCHED_TIMEOUT_EN enables the TIMEOUT abort in WAIT;
// without it WAIT is left only on disp_done and err_tmo stays 0.
module vend_dispense_sched
  import vend_pkg::*;
#(
  parameter  int N_STA   = 4,
  parameter  int TIMEOUT = 200,
  parameter  int GAP     = 3,
  localparam int IDXW    = $clog2(N_STA)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_STA-1:0]   req_valid,
  input  logic [2*N_STA-1:0] req_item,
  output logic [N_STA-1:0]   req_ready,
  output logic               disp_start,
  output logic [1:0]         disp_item,
  output logic [IDXW-1:0]    disp_sta,
  input  logic               disp_done,
  output logic [N_STA-1:0]   ack_valid,
  output logic               ack_ok,
  output logic               err_tmo
);

  if (N_STA < 2 || TIMEOUT < 2 || GAP < 0) begin : g_bad_param
    $error("vend_dispense_sched: illegal parameter value");
  end

  // Gap counter keeps at least one bit so GAP=0 still elaborates.
  localparam int             GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0]  GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  sched_st_t        st_q, st_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  item_t            item_q, item_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             ok_d, tmo_d;
  logic [N_STA-1:0] sel_d;
  logic [N_STA-1:0] ready_d, ackv_d;
  logic             start_d, ackok_d, err_d;

`ifdef VEND_SCHED_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0]            cnt_q, cnt_d;
`endif

  logic [N_STA-1:0] arb_gnt;
  logic [IDXW-1:0]  arb_idx;
  logic             arb_any;

  vend_rr_arb #(.N_STA(N_STA)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    ptr_d  = ptr_q;
    item_d = item_q;
    gap_d  = gap_q;
    ok_d   = 1'b0;
    tmo_d  = 1'b0;
`ifdef VEND_SCHED_TIMEOUT_EN
    cnt_d  = cnt_q;
`endif
    case (st_q)
      IDLE: begin
        if (arb_any) begin
          idx_d  = arb_idx;
          ptr_d  = arb_idx;
          item_d = ITEM_NONE;
          for (int unsigned i = 0; i < N_STA; i++) begin
            if (arb_gnt[i]) item_d = req_item[2*i +: 2];
          end
          st_d = GRANT;
        end
      end
      GRANT: begin
        // Item code 0 is rejected without touching the dispenser.
        if (item_q != ITEM_NONE) st_d = START;
        else                     st_d = ACK;
      end
      START: begin
        st_d = WAIT;
`ifdef VEND_SCHED_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      WAIT: begin
        // Completion takes precedence over a coincident timeout.
        if (disp_done) begin
          st_d = ACK;
          ok_d = 1'b1;
        end
`ifdef VEND_SCHED_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          st_d  = ACK;
          tmo_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TW'(1);
        end
`endif
      end
      ACK: begin
        if (GAP > 0) begin
          st_d  = GAPW;
          gap_d = '0;
        end else begin
          st_d = IDLE;
        end
      end
      GAPW: begin
        if (gap_q == GAP_LAST) st_d = IDLE;
        else                   gap_d = gap_q + GW'(1);
      end
      default: st_d = IDLE;
    endcase

    sel_d          = '0;
    sel_d[idx_d]   = 1'b1;
    ready_d        = (st_d == GRANT) ? sel_d : '0;
    start_d        = (st_d == START);
    ackv_d         = (st_d == ACK) ? sel_d : '0;
    ackok_d        = (st_d == ACK) && ok_d;
    err_d          = (st_d == ACK) && tmo_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= IDLE;
      idx_q      <= '0;
      ptr_q      <= IDXW'(N_STA - 1);
      item_q     <= ITEM_NONE;
      gap_q      <= '0;
      req_ready  <= '0;
      disp_start <= 1'b0;
      ack_valid  <= '0;
      ack_ok     <= 1'b0;
      err_tmo    <= 1'b0;
`ifdef VEND_SCHED_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      st_q       <= st_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      item_q     <= item_d;
      gap_q      <= gap_d;
      req_ready  <= ready_d;
      disp_start <= start_d;
      ack_valid  <= ackv_d;
      ack_ok     <= ackok_d;
      err_tmo    <= err_d;
`ifdef VEND_SCHED_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign disp_item = item_q;
  assign disp_sta  = idx_q;

endmodule

// File: tb/tb_vend_dispense_sched.sv
// Self-checking bench for vend_dispense_sched (N_STA=4, TIMEOUT=200, GAP=3).
// Directed transaction table, hand-written round-robin and reset sequences,
// then randomized traffic checked against a cycle-timing reference model.
module tb_vend_dispense_sched;

  localparam int N    = 4;
  localparam int TMO  = 200;
  localparam int GAP  = 3;
  localparam int RCYC = 1500;
  localparam int AW   = 2000;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_item;
  logic [N-1:0]   req_ready;
  logic           disp_start;
  logic [1:0]     disp_item;
  logic [1:0]     disp_sta;
  logic           disp_done;
  logic [N-1:0]   ack_valid;
  logic           ack_ok;
  logic           err_tmo;

  always #5 clk = ~clk;

  vend_dispense_sched #(.N_STA(N), .TIMEOUT(TMO), .GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_item   (req_item),
    .req_ready  (req_ready),
    .disp_start (disp_start),
    .disp_item  (disp_item),
    .disp_sta   (disp_sta),
    .disp_done  (disp_done),
    .ack_valid  (ack_valid),
    .ack_ok     (ack_ok),
    .err_tmo    (err_tmo)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    string name;
    int    sta;
    int    item;
    int    dly;     // done driven dly cycles after the start pulse; <0 = never
    bit    spur;    // extra done pulse during the grant cycle
    bit    exp_ok;
    bit    exp_tmo;
    int    lat;     // cycles from request drive to ack
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int sta, input bit v, input int item);
    logic [1:0] it;
    it = item[1:0];
    req_valid[sta]        = v;
    req_item[2*sta +: 2]  = it;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'({req_ready, disp_start, disp_item, disp_sta, ack_valid, ack_ok, err_tmo}), 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_item  = '0;
    disp_done = 1'b0;
    tick();
    tick();
    chk_all_zero("reset_outputs");
    rst = 1'b0;
  endtask

  // One isolated transaction; DUT must be idle on entry and is idle on exit.
  task automatic run_vec(input vec_t v);
    int ack_k;
    ack_k = -1;
    set_req(v.sta, 1'b1, v.item);
    disp_done = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      disp_done = 1'b0;
      if (k == 1) begin
        chk({v.name, "_ready"}, int'(req_ready), 1 << v.sta);
        req_valid = '0;
      end
      if (k == 2) begin
        chk({v.name, "_start"}, int'(disp_start), (v.item != 0) ? 1 : 0);
        if (v.item != 0) begin
          chk({v.name, "_item"}, int'(disp_item), v.item);
          chk({v.name, "_sta"}, int'(disp_sta), v.sta);
        end
      end
      if (ack_valid != '0) begin
        ack_k = k;
        break;
      end
      if (v.spur && k == 1) disp_done = 1'b1;
      if (v.dly > 0 && k == 2 + v.dly) disp_done = 1'b1;
    end
    chk({v.name, "_ack_lat"}, ack_k, v.lat);
    if (ack_k > 0) begin
      chk({v.name, "_ack_sta"}, int'(ack_valid), 1 << v.sta);
      chk({v.name, "_ack_ok"}, int'(ack_ok), int'(v.exp_ok));
      chk({v.name, "_err_tmo"}, int'(err_tmo), int'(v.exp_tmo));
      chk({v.name, "_sta_hold"}, int'(disp_sta), v.sta);
    end
    disp_done = 1'b0;
    repeat (GAP + 1) tick();
  endtask

  function automatic int rr_pick(input bit [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : main
    vec_t vt[$];
    int   n_gr, last_ack, done_at;
    int   exp_rdy[AW], exp_start[AW], exp_sitem[AW], exp_ssta[AW];
    int   exp_ack[AW], exp_ok[AW], exp_tmo[AW];
    bit [N-1:0] pend;
    int   itm[N];
    int   last, avail, wlo, whi, w, d, ack_c, okv, tov;

    vt.push_back('{"single_s1_i2",  1, 2,  5, 1'b0, 1'b1, 1'b0,   8});
    vt.push_back('{"item0_s2",      2, 0,  0, 1'b0, 1'b0, 1'b0,   2});
    vt.push_back('{"earliest_s3",   3, 3,  1, 1'b0, 1'b1, 1'b0,   4});
    vt.push_back('{"spur_done_s0",  0, 1,  3, 1'b1, 1'b1, 1'b0,   6});
    vt.push_back('{"long_s1_i3",    1, 3, 10, 1'b0, 1'b1, 1'b0,  13});
`ifdef VEND_SCHED_TIMEOUT_EN
    // 200 WAIT cycles without done: ack on the following cycle.
    vt.push_back('{"timeout_s2",    2, 1, -1, 1'b0, 1'b0, 1'b1, 203});
    vt.push_back('{"done_at_tmo",   0, 2, 200, 1'b0, 1'b1, 1'b0, 203});
    vt.push_back('{"done_pre_tmo",  3, 1, 199, 1'b0, 1'b1, 1'b0, 202});
`else
    vt.push_back('{"no_tmo_s2",     2, 1, 250, 1'b0, 1'b1, 1'b0, 253});
    vt.push_back('{"late_done_s0",  0, 2, 200, 1'b0, 1'b1, 1'b0, 203});
`endif

    do_reset();
    foreach (vt[i]) run_vec(vt[i]);

    // All stations request continuously: 0,1,2,3,0. After an ack there are
    // GAP gap cycles plus the arbitration cycle, so ready lands GAP+2 later.
    do_reset();
    req_valid = '1;
    req_item  = 8'b01_10_11_01;
    n_gr      = 0;
    last_ack  = -1;
    done_at   = -1;
    for (int k = 0; k < 200 && n_gr < 5; k++) begin
      tick();
      disp_done = 1'b0;
      if (req_ready != '0) begin
        chk("rr_order", int'(req_ready), 1 << (n_gr % N));
        if (n_gr > 0) chk("rr_spacing", cyc - last_ack, GAP + 2);
        n_gr++;
      end
      if (disp_start) done_at = cyc + 2;
      if (ack_valid != '0) begin
        chk("rr_ack_ok", int'(ack_ok), 1);
        last_ack = cyc;
      end
      if (cyc == done_at) disp_done = 1'b1;
    end
    chk("rr_grants", n_gr, 5);

    // Reset while waiting on the dispenser (station 2 in flight).
    do_reset();
    set_req(2, 1'b1, 1);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    #1 rst = 1'b1;
    #1 chk_all_zero("rst_in_wait");
    set_req(0, 1'b1, 2);
    set_req(3, 1'b1, 1);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_first_grant", int'(req_ready), 1);
    chk("rst_no_ack", int'(ack_valid), 0);

    // Randomized traffic against the timing model.
    for (int i = 0; i < AW; i++) begin
      exp_rdy[i] = 0; exp_start[i] = 0; exp_sitem[i] = 0; exp_ssta[i] = 0;
      exp_ack[i] = 0; exp_ok[i] = 0; exp_tmo[i] = 0;
    end
    do_reset();
    pend    = '0;
    last    = N - 1;
    avail   = 0;
    done_at = -1;
    wlo     = 1;
    whi     = 0;
    for (int s = 0; s < N; s++) itm[s] = 0;
    for (int r = 0; r < RCYC; r++) begin
      chk("rnd_ready", int'(req_ready), exp_rdy[r]);
      chk("rnd_start", int'(disp_start), exp_start[r]);
      if (exp_start[r] != 0) begin
        chk("rnd_item", int'(disp_item), exp_sitem[r]);
        chk("rnd_sta", int'(disp_sta), exp_ssta[r]);
      end
      chk("rnd_ack", int'(ack_valid), exp_ack[r]);
      chk("rnd_ok", int'(ack_ok), exp_ok[r]);
      chk("rnd_tmo", int'(err_tmo), exp_tmo[r]);

      pend = pend & ~exp_rdy[r][N-1:0];
      for (int s = 0; s < N; s++) begin
        if (!pend[s]) begin
          if ($urandom_range(0, 3) == 0) begin
            pend[s] = 1'b1;
            itm[s]  = int'($urandom_range(0, 3));
          end
        end else if ($urandom_range(0, 31) == 0) begin
          pend[s] = 1'b0;
        end
        set_req(s, pend[s], itm[s]);
      end

      if (r >= avail && pend != '0) begin
        w    = rr_pick(pend, last);
        last = w;
        exp_rdy[r+1] = 1 << w;
        if (itm[w] == 0) begin
          exp_ack[r+2] = 1 << w;
          avail = r + 3 + GAP;
        end else begin
          exp_start[r+2] = 1;
          exp_sitem[r+2] = itm[w];
          exp_ssta[r+2]  = w;
          d = int'($urandom_range(1, 12));
`ifdef VEND_SCHED_TIMEOUT_EN
          if ($urandom_range(0, 5) == 0) d = TMO + int'($urandom_range(0, 4));
`endif
          done_at = r + 2 + d;
          if (d <= TMO) begin
            ack_c = done_at + 1; okv = 1; tov = 0;
          end else begin
            ack_c = r + 3 + TMO; okv = 0; tov = 1;
          end
          exp_ack[ack_c] = 1 << w;
          exp_ok[ack_c]  = okv;
          exp_tmo[ack_c] = tov;
          wlo   = r + 3;
          whi   = ack_c - 1;
          avail = ack_c + GAP + 1;
        end
      end

      disp_done = (r == done_at) ||
                  (!(r >= wlo && r <= whi) && ($urandom_range(0, 5) == 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
